// File: rtl/hamming_decoder_11_7.sv
//------------------------------------------------------------------------------
// Module   : hamming_decoder_11_7
// Brief    : Registered SECDED decoder for the 12-bit extended Hamming(11,7)
//            code, 1-cycle latency. Correction enabled by macro
//            HAMMING_DECODER_CORRECT_EN (undefined: detect-only).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hamming_decoder_11_7 (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Valid,
  input  logic [11:0] i_CodeWord,
  output logic        o_Valid,
  output logic [4:0]  o_Syndrome,
  output logic [6:0]  o_DecodWord,
  output logic        o_ErrorC,
  output logic        o_ErrorD
);

  // Coverage masks over CW[10:0]: syndrome bit j covers positions with bit j set
  localparam logic [10:0] c_MASK_S0 = 11'h555;
  localparam logic [10:0] c_MASK_S1 = 11'h666;
  localparam logic [10:0] c_MASK_S2 = 11'h078;
  localparam logic [10:0] c_MASK_S3 = 11'h780;
  // Hamming position of each data bit, DW[0] in the low nibble
  localparam logic [27:0] c_DATA_POS = {4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3};

  logic [4:0] w_syndrome;
  logic [3:0] w_pos;
  logic [6:0] w_raw;
  logic [6:0] w_flip;
  logic [6:0] w_data;
  logic       w_fix_en;
  logic       w_err_c;
  logic       w_err_d;

  logic       r_valid;
  logic [4:0] r_syndrome;
  logic [6:0] r_data;
  logic       r_err_c;
  logic       r_err_d;

  always_comb begin
    w_syndrome[0] = ^(i_CodeWord[10:0] & c_MASK_S0);
    w_syndrome[1] = ^(i_CodeWord[10:0] & c_MASK_S1);
    w_syndrome[2] = ^(i_CodeWord[10:0] & c_MASK_S2);
    w_syndrome[3] = ^(i_CodeWord[10:0] & c_MASK_S3);
    w_syndrome[4] = ^i_CodeWord;
  end

  assign w_pos = w_syndrome[3:0];
  assign w_raw = {i_CodeWord[10], i_CodeWord[9], i_CodeWord[8], i_CodeWord[6],
                  i_CodeWord[5], i_CodeWord[4], i_CodeWord[2]};

`ifdef HAMMING_DECODER_CORRECT_EN
  always_comb begin
    w_fix_en = 1'b0;
    w_err_c  = 1'b0;
    w_err_d  = 1'b0;
    if (w_syndrome[4]) begin
      // Odd overall parity: a single error, unless P points past position 11
      if (w_pos <= 4'd11) begin
        w_fix_en = 1'b1;
        w_err_c  = 1'b1;
      end else begin
        w_err_d = 1'b1;
      end
    end else if (w_pos != 4'd0) begin
      w_err_d = 1'b1;
    end
  end
`else
  assign w_fix_en = 1'b0;
  assign w_err_c  = 1'b0;
  assign w_err_d  = |w_syndrome;
`endif

  // Check-bit and overall-parity errors never reach the data, so only data positions matter
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 7; i++) begin
      w_flip[i] = w_fix_en && (w_pos == c_DATA_POS[4*i +: 4]);
    end
  end

  assign w_data = w_raw ^ w_flip;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_valid    <= 1'b0;
      r_syndrome <= '0;
      r_data     <= '0;
      r_err_c    <= 1'b0;
      r_err_d    <= 1'b0;
    end else begin
      r_valid <= i_Valid;
      if (i_Valid) begin
        r_syndrome <= w_syndrome;
        r_data     <= w_data;
        r_err_c    <= w_err_c;
        r_err_d    <= w_err_d;
      end
    end
  end

  assign o_Valid     = r_valid;
  assign o_Syndrome  = r_syndrome;
  assign o_DecodWord = r_data;
  assign o_ErrorC    = r_err_c;
  assign o_ErrorD    = r_err_d;

endmodule

`default_nettype wire

// File: tb/tb_hamming_decoder_11_7.sv
//------------------------------------------------------------------------------
// Module   : tb_hamming_decoder_11_7
// Brief    : Self-checking bench for hamming_decoder_11_7 against an
//            arithmetic reference model; honours HAMMING_DECODER_CORRECT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hamming_decoder_11_7;

`ifdef HAMMING_DECODER_CORRECT_EN
  localparam bit c_CORR = 1'b1;
`else
  localparam bit c_CORR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] cw = '0;
  logic        out_valid;
  logic [4:0]  sy;
  logic [6:0]  dw;
  logic        ec;
  logic        ed;

  int n_checks = 0;
  int n_fails  = 0;

  logic       e_v  = 1'b0;
  logic [4:0] e_sy = '0;
  logic [6:0] e_dw = '0;
  logic       e_ec = 1'b0;
  logic       e_ed = 1'b0;

  hamming_decoder_11_7 dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Valid     (in_valid),
    .i_CodeWord  (cw),
    .o_Valid     (out_valid),
    .o_Syndrome  (sy),
    .o_DecodWord (dw),
    .o_ErrorC    (ec),
    .o_ErrorD    (ed)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, int'(out_valid), int'(e_v));
    check({tag, "_sy"},    int'(sy),        int'(e_sy));
    check({tag, "_dw"},    int'(dw),        int'(e_dw));
    check({tag, "_ec"},    int'(ec),        int'(e_ec));
    check({tag, "_ed"},    int'(ed),        int'(e_ed));
  endtask

  // Reference decode: syndrome as the XOR of the positions of all set bits
  task automatic model(input logic [11:0] w, output logic [4:0] o_sy, output logic [6:0] o_dw,
                       output logic o_ec, output logic o_ed);
    int p;
    int par;
    int dpos[7];
    logic [11:0] fixed;
    dpos = '{3, 5, 6, 7, 9, 10, 11};
    p = 0;
    par = 0;
    for (int k = 0; k < 12; k++) begin
      if (w[k]) begin
        par ^= 1;
        if (k < 11) p ^= (k + 1);
      end
    end
    o_sy  = {par[0], p[3:0]};
    fixed = w;
    o_ec  = 1'b0;
    o_ed  = 1'b0;
    if (c_CORR) begin
      if (par == 1 && p <= 11) begin
        o_ec = 1'b1;
        if (p > 0) fixed[p-1] = ~fixed[p-1];
      end else if (p != 0 || par != 0) begin
        o_ed = 1'b1;
      end
    end else begin
      o_ed = (p != 0 || par != 0);
    end
    for (int i = 0; i < 7; i++) o_dw[i] = fixed[dpos[i] - 1];
  endtask

  function automatic logic [11:0] encode(input logic [6:0] d);
    logic [11:0] w;
    int dpos[7];
    int p;
    dpos = '{3, 5, 6, 7, 9, 10, 11};
    w = '0;
    for (int i = 0; i < 7; i++) if (d[i]) w[dpos[i] - 1] = 1'b1;
    p = 0;
    for (int k = 0; k < 11; k++) if (w[k]) p ^= (k + 1);
    for (int j = 0; j < 4; j++) if (p[j]) w[(1 << j) - 1] = 1'b1;
    w[11] = ^w[10:0];
    return w;
  endfunction

  task automatic step(input logic v, input logic [11:0] w, input string tag);
    @(negedge clk);
    in_valid = v;
    cw = w;
    @(posedge clk);
    #1;
    if (v) model(w, e_sy, e_dw, e_ec, e_ed);
    e_v = v;
    check_all(tag);
  endtask

  initial begin
    logic [6:0]  data;
    logic [11:0] word;
    int          nerr;
    int          f0;
    int          f1;

    // Reset held with a valid all-ones word on the input
    in_valid = 1'b1;
    cw = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 12'h000, "zero");
    check("zero_lit_sy", int'(sy), 0);

    for (int k = 0; k < 12; k++) begin
      step(1'b1, 12'h001 << k, "sweep");
      check("sweep_lit_sy", int'(sy), (k < 11) ? (16 + k + 1) : 16);
      check("sweep_lit_dw", int'(dw), c_CORR ? 0 : int'(e_dw));
    end

    step(1'b1, 12'h807, "clean807");
    check("clean807_lit_dw", int'(dw), 1);
    step(1'b1, 12'h803, "single803");
    check("single803_lit_sy", int'(sy), 5'b10011);
`ifdef HAMMING_DECODER_CORRECT_EN
    check("single803_lit_dw", int'(dw), 1);
    check("single803_lit_ec", int'(ec), 1);
`else
    check("single803_lit_dw", int'(dw), 0);
    check("single803_lit_ed", int'(ed), 1);
`endif
    step(1'b1, 12'h003, "double003");
    check("double003_lit_ed", int'(ed), 1);
    step(1'b1, 12'h888, "invalid888");
    check("invalid888_lit_sy", int'(sy), 5'b11100);
    check("invalid888_lit_ed", int'(ed), 1);

    // Back-to-back stream then idle: outputs must hold
    for (int i = 0; i < 4; i++) step(1'b1, 12'($urandom_range(0, 4095)), "stream");
    step(1'b0, 12'($urandom_range(0, 4095)), "idle");
    step(1'b0, 12'($urandom_range(0, 4095)), "idle");

    // Random encoded words with 0, 1 or 2 injected errors
    for (int n = 0; n < 300; n++) begin
      data = 7'($urandom_range(0, 127));
      word = encode(data);
      nerr = $urandom_range(0, 2);
      f0 = $urandom_range(0, 11);
      f1 = (f0 + 1 + $urandom_range(0, 10)) % 12;
      if (nerr >= 1) word[f0] = ~word[f0];
      if (nerr == 2) word[f1] = ~word[f1];
      if (($urandom_range(0, 3)) == 0) begin
        step(1'b0, word, "rnd_idle");
      end else begin
        step(1'b1, word, "rnd");
        if (nerr == 0 || (c_CORR && nerr == 1)) check("rnd_data", int'(dw), int'(data));
      end
    end

    // Asynchronous reset mid-cycle with a result in flight
    step(1'b1, 12'h803, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    e_v = 1'b0; e_sy = '0; e_dw = '0; e_ec = 1'b0; e_ed = 1'b0;
    check_all("async_rst");
    in_valid = 1'b1;
    cw = 12'h888;
    @(posedge clk);
    #1;
    check_all("rst_inflight");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst");
    step(1'b1, 12'h807, "post_rst_word");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hamming_decoder_11_7.md
# hamming_decoder_11_7

Registered SECDED decoder for the 12-bit extended Hamming(11,7) code: recovers 7 data bits from a 12-bit codeword, corrects any single-bit error, and detects double-bit errors. It sits on the receive side of the protected datapath, downstream of the storage or channel and upstream of the data consumer. One codeword is accepted per clock with a fixed 1-cycle latency.

## Interface
- No parameters. The code geometry is fixed at 12 codeword bits, 7 data bits and a 5-bit syndrome.
- i_Clk  input  1  Single clock; all state updates on the rising edge.
- i_Rst_n  input  1  Reset, asynchronous, active-low.
- i_Valid  input  1  Qualifies i_CodeWord.
- i_CodeWord  input  12  Received codeword.
- o_Valid  output  1  Outputs hold a new result.
- o_Syndrome  output  5  {overall parity check, 4-bit Hamming syndrome}.
- o_DecodWord  output  7  Decoded (corrected) data.
- o_ErrorC  output  1  Single error detected and corrected.
- o_ErrorD  output  1  Uncorrectable error detected.

## Operation
Bit mapping:
- i_CodeWord[k] is Hamming position k+1 for k=0..10.
- Check bits are at positions 1, 2, 4 and 8 (CW[0], CW[1], CW[3], CW[7]).
- CW[11] is the overall even-parity bit covering all 12 bits.
- Data bits: DW[0]=CW[2], DW[1]=CW[4], DW[2]=CW[5], DW[3]=CW[6], DW[4]=CW[8], DW[5]=CW[9], DW[6]=CW[10].

Syndrome:
- S[j] for j=0..3 is the XOR of all positions p in 1..11 whose bit j is set.
- S[4] is the XOR of all 12 codeword bits.

Decision rules (P = S[3:0]):
- S = 0: no error. DW = raw data, EC=0, ED=0.
- S[4]=1, P=0: the overall parity bit is in error. DW = raw data, EC=1, ED=0.
- S[4]=1, P in 1..11: flip position P, then extract data. EC=1, ED=0.
- S[4]=1, P in 12..15: invalid syndrome. DW = raw data, EC=0, ED=1.
- S[4]=0, P≠0: double error. DW = raw data, EC=0, ED=1.

General rules:
- EC and ED are mutually exclusive.
- o_Syndrome always reports S, even when an error is corrected.

## Timing
- All outputs are registered.
- Reset values: o_Valid=0, o_Syndrome=0, o_DecodWord=0, o_ErrorC=0, o_ErrorD=0.
- Reset is applied asynchronously and released synchronously to i_Clk by the upstream reset logic.
- Latency: a codeword sampled with i_Valid=1 on edge N appears on all outputs after edge N, with o_Valid=1 for that cycle.
- o_Valid is i_Valid delayed by one cycle.
- When i_Valid=0, o_Valid goes to 0 and the data, syndrome and flag outputs hold their last values.
- Back-to-back valid inputs produce back-to-back results. There is no stall and no backpressure.
- Reset asserted mid-stream clears all outputs immediately, and any in-flight result is discarded.

## Configuration
- Macro: HAMMING_DECODER_CORRECT_EN.
- Defined: correction is performed exactly as described in Operation.
- Undefined: detect-only mode.
  - o_DecodWord always carries the raw data bits.
  - o_ErrorC is tied to 0.
  - o_ErrorD is set for any nonzero syndrome.
  - o_Syndrome and timing are unchanged.

## Test plan
- Reset: hold i_Rst_n=0 with i_Valid=1 and i_CodeWord=0xFFF → all outputs stay 0. Release reset, then apply 0x000 valid → next cycle SY=00000, DW=0000000, EC=0, ED=0, o_Valid=1.
- Single-bit sweep on the all-zero codeword, 0x000 XOR (1<<k) for k=0..11:
  - k=0..10 → SY={1, (k+1) as 4 bits}, DW=0000000, EC=1, ED=0.
  - k=11 → SY=10000, DW=0000000, EC=1, ED=0.
- Clean codeword 0x807 (data 0000001) → SY=00000, DW=0000001, EC=0. The same word with CW[2] flipped (0x803) → SY=10011, DW=0000001, EC=1, ED=0.
- Double error 0x003 → SY=00011, DW=0000000, EC=0, ED=1.
- Invalid syndrome 0x888 → SY=11100, EC=0, ED=1, DW=0000000.
- Streaming: four consecutive valid words, then i_Valid=0 → each result appears one cycle after its input; o_Valid drops and outputs hold. Rebuild with HAMMING_DECODER_CORRECT_EN undefined and apply 0x803 → DW=0000000, EC=0, ED=1.
